// File: rtl/id_ex_reg_if.sv
// ID/EX bundle: decoded fields from ID and the registered copy presented to EX.
interface id_ex_reg_if;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_data;
   logic [31:0] id_rs2_data;
   logic [4:0]  id_rs1;
   logic [4:0]  id_rs2;
   logic [4:0]  id_rd;
   logic [31:0] id_imm;
   logic [7:0]  id_ctrl;

   logic        ex_valid;
   logic [31:0] ex_pc;
   logic [31:0] rs1_IDEX;
   logic [31:0] rs2_IDEX;
   logic [4:0]  ex_rs1;
   logic [4:0]  ex_rs2;
   logic [4:0]  ex_rd;
   logic [31:0] ex_imm;
   logic [7:0]  ex_ctrl;

   modport master (
      output id_valid, id_pc, id_rs1_data, id_rs2_data,
      output id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
      input  ex_valid, ex_pc, rs1_IDEX, rs2_IDEX,
      input  ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl
   );

   modport slave (
      input  id_valid, id_pc, id_rs1_data, id_rs2_data,
      input  id_rs1, id_rs2, id_rd, id_imm, id_ctrl,
      output ex_valid, ex_pc, rs1_IDEX, rs2_IDEX,
      output ex_rs1, ex_rs2, ex_rd, ex_imm, ex_ctrl
   );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use stall, flush and hazard counters.
// Optional WB-to-ID operand bypass: define ID_EX_WB_BYPASS_EN.
module id_ex_reg #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   id_ex_reg_if.slave       bus,
   input  logic             flush,
   input  logic             wb_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic [31:0]      wb_write_data,
   output logic             stall,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [7:0]  ctrl;
   } ex_t;

   ex_t         st_q;
   ex_t         st_d;
   logic        haz;
   logic        rd_hit;
   logic [31:0] op1;
   logic [31:0] op2;

   assign rd_hit = (st_q.rd == bus.id_rs1) |
                   (st_q.rd == bus.id_rs2);

   assign haz = st_q.valid & st_q.ctrl[1] &
                (st_q.rd != 5'd0) & bus.id_valid & rd_hit;

   assign stall = haz & ~flush;

`ifdef ID_EX_WB_BYPASS_EN
   logic byp1;
   logic byp2;

   // Regfile may return stale data when WB writes the same index
   assign byp1 = wb_reg_write & (wb_rd != 5'd0) &
                 (wb_rd == bus.id_rs1);
   assign byp2 = wb_reg_write & (wb_rd != 5'd0) &
                 (wb_rd == bus.id_rs2);
   assign op1 = byp1 ? wb_write_data : bus.id_rs1_data;
   assign op2 = byp2 ? wb_write_data : bus.id_rs2_data;
`else
   logic wb_unused;

   assign wb_unused = ^{wb_reg_write, wb_rd, wb_write_data};
   assign op1 = bus.id_rs1_data;
   assign op2 = bus.id_rs2_data;
`endif

   always_comb begin
      st_d = '0;
      if (!flush && !haz) begin
         st_d.valid    = bus.id_valid;
         st_d.pc       = bus.id_pc;
         st_d.rs1_data = op1;
         st_d.rs2_data = op2;
         st_d.rs1      = bus.id_rs1;
         st_d.rs2      = bus.id_rs2;
         st_d.rd       = bus.id_rd;
         st_d.imm      = bus.id_imm;
         st_d.ctrl     = bus.id_valid ? bus.id_ctrl : 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= '0;
      else        st_q <= st_d;
   end

   // Counters hold at all-ones instead of wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && bus.id_valid && flush_cnt != '1)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

   assign bus.ex_valid = st_q.valid;
   assign bus.ex_pc    = st_q.pc;
   assign bus.rs1_IDEX = st_q.rs1_data;
   assign bus.rs2_IDEX = st_q.rs2_data;
   assign bus.ex_rs1   = st_q.rs1;
   assign bus.ex_rs2   = st_q.rs2;
   assign bus.ex_rd    = st_q.rd;
   assign bus.ex_imm   = st_q.imm;
   assign bus.ex_ctrl  = st_q.ctrl;

endmodule

// File: tb/tb_id_ex_reg.sv
// Random + directed bench for id_ex_reg against a behavioural model.
// Counter width is 4 so saturation is reachable.
module tb_id_ex_reg;
   localparam int CW  = 4;
   localparam int MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          wb_reg_write;
   logic [4:0]    wb_rd;
   logic [31:0]   wb_write_data;
   logic          stall;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   id_ex_reg_if bus ();

   id_ex_reg #(.CNT_W(CW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .flush         (flush),
      .wb_reg_write  (wb_reg_write),
      .wb_rd         (wb_rd),
      .wb_write_data (wb_write_data),
      .stall         (stall),
      .stall_cnt     (stall_cnt),
      .flush_cnt     (flush_cnt)
   );

   always #5 clk = ~clk;

   int n_tot  = 0;
   int n_pass = 0;

   // Model of what EX must hold
   bit          m_valid;
   logic [31:0] m_pc, m_r1d, m_r2d, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd;
   logic [7:0]  m_ctrl;
   int          m_scnt, m_fcnt;

   function automatic void chk(string nm, logic [31:0] act,
                               logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endfunction

   function automatic void model_clear();
      m_valid = 0; m_pc = 0; m_r1d = 0; m_r2d = 0; m_imm = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
      m_scnt = 0; m_fcnt = 0;
   endfunction

   function automatic bit model_haz();
      bit is_load = m_valid && m_ctrl[1] && m_rd != 0;
      bit uses = (m_rd == bus.id_rs1) || (m_rd == bus.id_rs2);
      return is_load && bus.id_valid && uses;
   endfunction

   function automatic logic [31:0] fwd(logic [4:0] idx,
                                       logic [31:0] rf);
`ifdef ID_EX_WB_BYPASS_EN
      if (wb_reg_write && wb_rd != 0 && wb_rd == idx)
         return wb_write_data;
`endif
      return rf;
   endfunction

   task automatic compare_regs();
      chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
      chk("ex_pc", bus.ex_pc, m_pc);
      chk("rs1_IDEX", bus.rs1_IDEX, m_r1d);
      chk("rs2_IDEX", bus.rs2_IDEX, m_r2d);
      chk("ex_rs1", 32'(bus.ex_rs1), 32'(m_rs1));
      chk("ex_rs2", 32'(bus.ex_rs2), 32'(m_rs2));
      chk("ex_rd", 32'(bus.ex_rd), 32'(m_rd));
      chk("ex_imm", bus.ex_imm, m_imm);
      chk("ex_ctrl", 32'(bus.ex_ctrl), 32'(m_ctrl));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_scnt));
      chk("flush_cnt", 32'(flush_cnt), 32'(m_fcnt));
   endtask

   // One clock: check stall, advance model on the edge, check regs
   task automatic tick();
      bit h, s;
      #1;
      h = model_haz();
      s = h && !flush;
      chk("stall", 32'(stall), 32'(s));
      @(posedge clk);
      if (s && m_scnt < MAX) m_scnt++;
      if (flush && bus.id_valid && m_fcnt < MAX) m_fcnt++;
      if (flush || h) begin
         m_valid = 0; m_pc = 0; m_r1d = 0; m_r2d = 0; m_imm = 0;
         m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_ctrl = 0;
      end else begin
         m_valid = bus.id_valid;
         m_pc    = bus.id_pc;
         m_r1d   = fwd(bus.id_rs1, bus.id_rs1_data);
         m_r2d   = fwd(bus.id_rs2, bus.id_rs2_data);
         m_rs1   = bus.id_rs1;
         m_rs2   = bus.id_rs2;
         m_rd    = bus.id_rd;
         m_imm   = bus.id_imm;
         m_ctrl  = bus.id_valid ? bus.id_ctrl : 8'h0;
      end
      @(negedge clk);
      #1;
      compare_regs();
   endtask

   task automatic drive(bit v, logic [31:0] pc, logic [4:0] r1,
                        logic [4:0] r2, logic [4:0] rd,
                        logic [7:0] ctrl, bit fl);
      bus.id_valid    = v;
      bus.id_pc       = pc;
      bus.id_rs1      = r1;
      bus.id_rs2      = r2;
      bus.id_rd       = rd;
      bus.id_ctrl     = ctrl;
      bus.id_imm      = pc ^ 32'h5A5A_0000;
      bus.id_rs1_data = pc + 32'h11;
      bus.id_rs2_data = pc + 32'h22;
      flush           = fl;
   endtask

   task automatic drive_rand();
      bus.id_valid    = ($urandom % 4) != 0;
      bus.id_pc       = $urandom;
      bus.id_rs1_data = $urandom;
      bus.id_rs2_data = $urandom;
      bus.id_rs1      = 5'($urandom % 8);
      bus.id_rs2      = 5'($urandom % 8);
      bus.id_rd       = 5'($urandom % 8);
      bus.id_imm      = $urandom;
      bus.id_ctrl     = 8'($urandom) | (($urandom % 2) ? 8'h02 : 8'h00);
      flush           = ($urandom % 8) == 0;
      wb_reg_write    = $urandom % 2;
      wb_rd           = 5'($urandom % 8);
      wb_write_data   = $urandom;
   endtask

   initial begin
      logic [31:0] exp_byp;
      rst_n = 1'b0;
      wb_reg_write = 0; wb_rd = 0; wb_write_data = 0;
      drive(0, 0, 0, 0, 0, 0, 0);
      model_clear();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ex_valid", 32'(bus.ex_valid), 0);
      chk("rst_stall_cnt", 32'(stall_cnt), 0);
      compare_regs();
      @(negedge clk);
      rst_n = 1'b1;

      // Load-use: load to x5, consumer reads x5 via rs2
      drive(1, 32'h100, 5'd1, 5'd2, 5'd5, 8'h0B, 0);
      tick();
      chk("ld_ctrl", 32'(bus.ex_ctrl), 32'h0B);
      drive(1, 32'h104, 5'd3, 5'd5, 5'd6, 8'h01, 0);
      #1;
      chk("lu_stall", 32'(stall), 1);
      tick();
      chk("lu_bubble_valid", 32'(bus.ex_valid), 0);
      chk("lu_bubble_ctrl", 32'(bus.ex_ctrl), 0);
      chk("lu_stall_cnt", 32'(stall_cnt), 1);
      chk("lu_stall_clear", 32'(stall), 0);
      tick();
      chk("lu_capture_pc", bus.ex_pc, 32'h104);

      // Load to x0 never stalls
      drive(1, 32'h200, 5'd1, 5'd2, 5'd0, 8'h0B, 0);
      tick();
      drive(1, 32'h204, 5'd0, 5'd0, 5'd6, 8'h01, 0);
      #1;
      chk("x0_stall", 32'(stall), 0);
      tick();
      chk("x0_capture_pc", bus.ex_pc, 32'h204);
      // Non-load producer of x6 never stalls
      drive(1, 32'h208, 5'd6, 5'd1, 5'd7, 8'h01, 0);
      #1;
      chk("nonload_stall", 32'(stall), 0);
      tick();
      chk("nonload_pc", bus.ex_pc, 32'h208);

      // Flush with hazard pending
      drive(1, 32'h300, 5'd1, 5'd2, 5'd5, 8'h0B, 0);
      tick();
      drive(1, 32'h304, 5'd5, 5'd2, 5'd6, 8'h01, 1);
      #1;
      chk("fl_stall", 32'(stall), 0);
      tick();
      chk("fl_bubble", 32'(bus.ex_valid), 0);
      chk("fl_flush_cnt", 32'(flush_cnt), 1);
      chk("fl_stall_cnt", 32'(stall_cnt), 1);

      // WB write to x7 while ID reads x7
      drive(1, 32'h400, 5'd7, 5'd2, 5'd8, 8'h01, 0);
      bus.id_rs1_data = 32'h0;
      wb_reg_write = 1; wb_rd = 5'd7; wb_write_data = 32'hDEADBEEF;
`ifdef ID_EX_WB_BYPASS_EN
      exp_byp = 32'hDEADBEEF;
`else
      exp_byp = 32'h0;
`endif
      tick();
      chk("wb_bypass", bus.rs1_IDEX, exp_byp);
      wb_reg_write = 0;

      // 20 flushes saturate the 4-bit counter
      drive(1, 32'h500, 5'd1, 5'd2, 5'd3, 8'h01, 1);
      repeat (20) tick();
      chk("flush_sat", 32'(flush_cnt), 32'(MAX));

      repeat (400) begin
         drive_rand();
         tick();
      end

      // Async reset in mid-cycle with a live EX entry
      drive(1, 32'h600, 5'd1, 5'd2, 5'd3, 8'h01, 0);
      wb_reg_write = 0;
      tick();
      chk("pre_rst_valid", 32'(bus.ex_valid), 1);
      #2;
      rst_n = 1'b0;
      #1;
      model_clear();
      chk("arst_valid", 32'(bus.ex_valid), 0);
      chk("arst_flush_cnt", 32'(flush_cnt), 0);
      chk("arst_stall", 32'(stall), 0);
      compare_regs();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 32'h40, 5'd1, 5'd2, 5'd3, 8'h01, 0);
      tick();
      chk("post_rst_pc", bus.ex_pc, 32'h40);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register of the five-stage core. It captures decoded operands, register indices, immediate and control from the ID stage. It presents them to EX as `rs1_IDEX`/`rs2_IDEX` etc., the inputs of the EX forwarding muxes. It also detects load-use hazards, inserting one bubble while asserting `stall` to the PC and IF/ID registers, applies branch flushes, and keeps saturating hazard counters.

## Interface
Parameters:
- `CNT_W`, 16: width of the stall and flush event counters.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc` in 32: PC of the ID instruction.
- `id_rs1_data`, `id_rs2_data` in 32 each: register file read data.
- `id_rs1`, `id_rs2`, `id_rd` in 5 each: register indices.
- `id_imm` in 32: sign-extended immediate.
- `id_ctrl` in 8: bit 0 RegWrite, 1 MemRead, 2 MemWrite, 3 MemtoReg, 4 ALUSrc, 7:5 ALUOp.
- `flush` in 1: branch/jump taken in EX; kill the ID instruction.
- `wb_reg_write` in 1, `wb_rd` in 5, `wb_write_data` in 32: WB-stage write port, also the regfile write.
- `ex_valid` out 1, `ex_pc` out 32, `rs1_IDEX` out 32, `rs2_IDEX` out 32: registered EX-stage operands.
- `ex_rs1`, `ex_rs2`, `ex_rd` out 5, `ex_imm` out 32, `ex_ctrl` out 8: registered EX-stage fields.
- `stall` out 1: combinational; holds PC and IF/ID this cycle.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating event counters.

## Operation
- Hazard: `haz = ex_valid & ex_ctrl[1] & (ex_rd != 0) & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
- Output: `stall = haz & ~flush`.
- Next-state selection, in priority order:
  - `flush`: load a bubble (`ex_valid`=0, `ex_ctrl`=0, all data/index fields 0).
  - `haz`: load a bubble as above.
  - Otherwise: capture all ID fields. `ex_valid` = `id_valid`. `ex_ctrl` = `id_valid ? id_ctrl : 0`.
- Bubble states: the register is effectively RUN/BUBBLE. A load-use hazard always yields exactly one bubble. In the following cycle the EX slot holds a bubble, so `haz`=0 and the held ID instruction is captured.
- Register x0: indices equal to 0 never trigger a hazard or a bypass.
- Counters:
  - `stall_cnt` +1 on each cycle with `stall`=1.
  - `flush_cnt` +1 on each cycle with `flush`=1 and `id_valid`=1.
  - Both saturate at all-ones and never wrap.
- Simultaneous `flush` and `haz`: flush wins, `stall`=0, only `flush_cnt` may increment.

## Timing
- Latency: one cycle from ID inputs to `ex_*`/`rs*_IDEX` outputs.
- `stall` is combinational from the current `ex_*` register state and the ID inputs; no extra cycle.
- Reset: all outputs 0 immediately on `rst_n` low, independent of `clk`. This covers `ex_valid`, `ex_ctrl`, data, indices, and both counters. `stall` is 0 because `ex_valid`=0.
- Reset mid-stall: pending bubble discarded; after release the first edge captures ID normally.
- Deasserting reset takes effect at the next rising `clk` edge only.

## Configuration
- Macro: `ID_EX_WB_BYPASS_EN`.
- Defined:
  - When a register is captured and `wb_reg_write & wb_rd != 0 & wb_rd == id_rs1`, `rs1_IDEX` takes `wb_write_data` instead of `id_rs1_data`.
  - Same rule for `rs2_IDEX` using `id_rs2`.
  - This covers regfiles that do not write-before-read.
- Undefined: `rs1_IDEX`/`rs2_IDEX` always take the regfile data. The regfile must provide the write-first behaviour itself.

## Test plan
- Reset:
  - Stimulus: drive `rst_n`=0 mid-cycle with `ex_valid`=1 and counters nonzero.
  - Response: all outputs 0 without a clock edge; first edge after release captures `id_pc`=0x40.
- Load-use stall:
  - Stimulus: EX holds `ex_ctrl[1]`=1, `ex_rd`=5; ID has `id_rs2`=5, `id_valid`=1.
  - Response: `stall`=1 for one cycle. Next edge gives `ex_valid`=0, `ex_ctrl`=0 and `stall_cnt`=1. The following edge captures the ID instruction and `stall`=0.
- x0 and non-load: same as the load-use case but with `ex_rd`=0, or with `ex_ctrl[1]`=0 → `stall`=0 and the ID instruction is captured directly.
- Flush beats stall:
  - Stimulus: assert `flush`=1 while the hazard condition is true.
  - Response: `stall`=0, bubble loaded, `flush_cnt` +1, `stall_cnt` unchanged.
- WB bypass (with `ID_EX_WB_BYPASS_EN`):
  - Stimulus: `wb_reg_write`=1, `wb_rd`=7, `wb_write_data`=0xDEADBEEF, `id_rs1`=7, `id_rs1_data`=0x0.
  - Response: `rs1_IDEX`=0xDEADBEEF. Without the macro, `rs1_IDEX`=0x0.
- Saturation:
  - Stimulus: with `CNT_W`=4, apply 20 flush cycles with `id_valid`=1.
  - Response: `flush_cnt` stops at 15.
